// File: rtl/mul_pipe_if.sv
// Operand/result channel bundle for mul_pipe_unit: valid/ready in, valid/ready out.
// The master side offers operations and consumes results; the slave side is the multiplier.
interface mul_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  signed_i;
  logic                  high_i;
  logic [TAG_WIDTH-1:0]  tag_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] c_o;
  logic [TAG_WIDTH-1:0]  tag_o;

  modport master (
    output in_valid_i, a_i, b_i, signed_i, high_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, c_o, tag_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, signed_i, high_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, c_o, tag_o
  );
endinterface

// File: rtl/mul_pipe_unit.sv
// Pipelined signed/unsigned multiplier returning the upper or lower product half,
// with a tag carried alongside; the whole pipe stalls as one when the output is blocked.
module mul_pipe_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_KIND   = 0,
  parameter int LATENCY    = 3,
  parameter int TAG_WIDTH  = 4
) (
  input logic       clk_i,
  input logic       rst_i,
  mul_pipe_if.slave bus
);
  localparam int W = DATA_WIDTH;

  logic                 adv;
  logic [W-1:0]         prod_in;
  logic [LATENCY-1:0]   vld_p;
  logic [W-1:0]         res_p [LATENCY];
  logic [TAG_WIDTH-1:0] tag_p [LATENCY];

  // Extending both operands to 2W bits makes the 2W-bit wrap-around product exact
  // for either signedness, so one multiplier serves both modes.
  function automatic logic [W-1:0] mul_select(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         sgn,
    input logic         hi
  );
    logic signed [2*W-1:0] ax;
    logic signed [2*W-1:0] bx;
    logic signed [2*W-1:0] p;
    ax = {{W{sgn & a[W-1]}}, a};
    bx = {{W{sgn & b[W-1]}}, b};
    p  = ax * bx;
    return hi ? p[2*W-1:W] : p[W-1:0];
  endfunction

  if (ALU_KIND == 0) begin : g_behav
    assign prod_in = mul_select(bus.a_i, bus.b_i, bus.signed_i, bus.high_i);
  end else begin : g_reserved
    // Reserved selectors fall back to the behavioural multiplier.
    assign prod_in = mul_select(bus.a_i, bus.b_i, bus.signed_i, bus.high_i);
  end

  assign adv            = !bus.out_valid_o || bus.out_ready_i;
  assign bus.in_ready_o = adv;

  // Stage 0 captures the product; later stages only shift it so retiming can spread the multiply.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[0] <= bus.in_valid_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv) begin
      res_p[0] <= prod_in;
      tag_p[0] <= bus.tag_i;
      for (int i = 1; i < LATENCY; i++) begin
        res_p[i] <= res_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  // Output stage: data is unreset, so it is masked to zero whenever no result is presented.
  assign bus.out_valid_o = vld_p[LATENCY-1];
  assign bus.c_o         = vld_p[LATENCY-1] ? res_p[LATENCY-1] : '0;
  assign bus.tag_o       = vld_p[LATENCY-1] ? tag_p[LATENCY-1] : '0;
endmodule

// File: tb/tb_mul_pipe_unit.sv
// Randomized and directed bench for mul_pipe_unit against a queue-based reference model
// that tracks each accepted operation and the advancing cycle at which it must appear.
module tb_mul_pipe_unit;
  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int LAT = 3;

  logic clk;
  logic rst;

  mul_pipe_if #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) bus ();

  mul_pipe_unit #(
    .DATA_WIDTH(W),
    .ALU_KIND  (0),
    .LATENCY   (LAT),
    .TAG_WIDTH (TW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  c;
    logic [TW-1:0] tag;
    int            due;
  } exp_t;

  exp_t q[$];
  int   out_cycles[$];
  int   checks = 0;
  int   errors = 0;
  int   adv_cnt = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference product straight from integer arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic h);
    longint unsigned p;
    if (s) p = longint'(int'(a)) * longint'(int'(b));
    else   p = longint'({32'd0, a}) * longint'({32'd0, b});
    return h ? p[63:32] : p[31:0];
  endfunction

  // Per-cycle compare process, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin
    logic exp_v;
    logic adv_m;
    exp_t e;
    cyc++;
    exp_v = (q.size() > 0) && (q[0].due <= adv_cnt);
    chk("out_valid", bus.out_valid_o, exp_v);
    chk("in_ready", bus.in_ready_o, !exp_v || bus.out_ready_i);
    if (exp_v && bus.out_valid_o) begin
      chk("c_o", bus.c_o, q[0].c);
      chk("tag_o", bus.tag_o, q[0].tag);
    end
    adv_m = !exp_v || bus.out_ready_i;
    if (exp_v && bus.out_ready_i) begin
      void'(q.pop_front());
      out_cycles.push_back(cyc);
    end
    if (rst) begin
      q.delete();
    end else if (adv_m && bus.in_valid_i) begin
      e.c   = model(bus.a_i, bus.b_i, bus.signed_i, bus.high_i);
      e.tag = bus.tag_i;
      e.due = adv_cnt + LAT;
      q.push_back(e);
    end
    if (adv_m) adv_cnt++;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic h, input logic [TW-1:0] t, output int waited);
    bit got;
    bus.a_i = a; bus.b_i = b; bus.signed_i = s; bus.high_i = h; bus.tag_i = t;
    bus.in_valid_i = 1'b1;
    waited = 0;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = bus.in_ready_o && !rst;
      @(posedge clk); #1;
      if (!got) waited++;
    end
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bus.in_valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic latency_probe(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_c, input logic [TW-1:0] t);
    int w;
    send(a, b, 1'b0, 1'b0, t, w);
    bus.in_valid_i = 1'b0;
    chk("lat_c1_valid", bus.out_valid_o, 0);
    @(posedge clk); #1;
    chk("lat_c2_valid", bus.out_valid_o, 0);
    @(posedge clk); #1;
    chk("lat_c3_valid", bus.out_valid_o, 1);
    chk("lat_c3_c", bus.c_o, exp_c);
    chk("lat_c3_tag", bus.tag_o, t);
  endtask

  initial begin
    int w;
    logic [W-1:0] hold_c;
    logic [TW-1:0] hold_t;
    logic [W-1:0] ra, rb;

    // Pin the model with hand-computed products.
    chk("model_s_hi_ff", model(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1), 32'h00000000);
    chk("model_s_lo_ff", model(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0), 32'h00000001);
    chk("model_u_hi_ff", model(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1), 32'hFFFFFFFE);
    chk("model_s_hi_min", model(32'h80000000, 32'h1, 1, 1), 32'hFFFFFFFF);
    chk("model_u_hi_min", model(32'h80000000, 32'h1, 0, 1), 32'h00000000);
    chk("model_u_lo_3x5", model(32'd3, 32'd5, 0, 0), 32'h0000000F);

    // Reset with an operation offered: must not be accepted, in_ready stays 1.
    rst = 1'b1;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.a_i = 32'd7; bus.b_i = 32'd9; bus.signed_i = 1'b0; bus.high_i = 1'b0; bus.tag_i = 4'h3;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_in_ready", bus.in_ready_o, 1);
    end
    bus.in_valid_i = 1'b0;
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_c_zero", bus.c_o, 0);
    chk("rst_tag_zero", bus.tag_o, 0);
    @(posedge clk); #1;
    chk("rst_no_accept", bus.out_valid_o, 0);

    latency_probe(32'd3, 32'd5, 32'h0000000F, 4'hA);
    idle(3);

    // Signedness / half selection corners, back to back.
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 4'h1, w);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 4'h2, w);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 4'h3, w);
    send(32'h80000000, 32'h00000001, 1, 1, 4'h4, w);
    send(32'h80000000, 32'h00000001, 0, 1, 4'h5, w);
    send(32'h7FFFFFFF, 32'h80000000, 1, 1, 4'h6, w);
    idle(6);

    // Throughput: 16 back-to-back with the consumer always ready.
    out_cycles.delete();
    for (int i = 0; i < 16; i++) begin
      send($urandom, $urandom, 1'($urandom), 1'($urandom), 4'(i), w);
      chk("tput_in_ready", w, 0);
    end
    idle(6);
    chk("tput_count", out_cycles.size(), 16);
    if (out_cycles.size() == 16) chk("tput_consecutive", out_cycles[15] - out_cycles[0], 15);

    // Backpressure: consumer stalls for 5 cycles while 6 operations stream in.
    out_cycles.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom), 4'(i + 8), w);
        bus.in_valid_i = 1'b0;
      end
      begin
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
          if (k >= 3) begin
            chk("bp_in_ready_low", bus.in_ready_o, 0);
            chk("bp_out_valid", bus.out_valid_o, 1);
            if (k == 3) begin
              hold_c = bus.c_o;
              hold_t = bus.tag_o;
            end else begin
              chk("bp_c_stable", bus.c_o, hold_c);
              chk("bp_tag_stable", bus.tag_o, hold_t);
            end
          end
          @(posedge clk); #1;
        end
        bus.out_ready_i = 1'b1;
      end
    join
    idle(8);
    chk("bp_count", out_cycles.size(), 6);

    // Reset mid-flight: three operations held in the pipe are discarded.
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, 4'hC, w);
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", bus.out_valid_o, 0);
    bus.out_ready_i = 1'b1;
    out_cycles.delete();
    latency_probe(32'd12, 32'd11, 32'd132, 4'h7);
    idle(4);
    chk("midrst_only_new", out_cycles.size(), 1);

    // Bubbles: alternate valid for 10 cycles.
    out_cycles.delete();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid_i = (i % 2 == 0);
      bus.a_i = $urandom; bus.b_i = $urandom;
      bus.signed_i = 1'($urandom); bus.high_i = 1'($urandom); bus.tag_i = 4'($urandom);
      @(posedge clk); #1;
    end
    idle(6);
    chk("bubble_count", out_cycles.size(), 5);
    for (int i = 1; i < 5 && i < out_cycles.size(); i++)
      chk("bubble_alternate", out_cycles[i] - out_cycles[i-1], 2);

    // Random traffic with random backpressure and occasional reset.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h7FFFFFFF;
        default: ;
      endcase
      bus.a_i = ra; bus.b_i = rb;
      bus.signed_i = 1'($urandom); bus.high_i = 1'($urandom); bus.tag_i = 4'($urandom);
      bus.in_valid_i = ($urandom_range(0, 3) != 0);
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    idle(10);
    chk("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_pipe_unit.md
MUL_PIPE_UNIT -- requirements
Module: mul_pipe_unit

Interface
Parameters:
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and result width in bits; legal range 2..64.
REQ-002 SHALL have parameter ALU_KIND, default 0: implementation selector; 0 = behavioural multiply, other values reserved and SHALL behave identically to 0.
REQ-003 SHALL have parameter LATENCY, default 3: pipeline depth in cycles from input handshake to out_valid_o; legal range 1..8.
REQ-004 SHALL have parameter TAG_WIDTH, default 4: width of the sideband tag carried alongside each operation; legal range 1..16.

Ports (name, direction, width, meaning):
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
REQ-006 Input channel:
- in_valid_i  in  1  operation offered.
- in_ready_o  out  1  block accepts an operation this cycle.
- a_i  in  DATA_WIDTH  multiplicand.
- b_i  in  DATA_WIDTH  multiplier.
- signed_i  in  1  1 = both operands two's complement; 0 = both unsigned.
- high_i  in  1  1 = return upper half of the product; 0 = return lower half.
- tag_i  in  TAG_WIDTH  opaque sideband value.
REQ-007 Output channel:
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts the result.
- c_o  out  DATA_WIDTH  result.
- tag_o  out  TAG_WIDTH  tag of the result.

Function
REQ-008 SHALL form the full 2*DATA_WIDTH-bit product of a_i and b_i, sign-extending both operands when signed_i=1 and zero-extending them when signed_i=0.
REQ-009 SHALL set c_o to product[2W-1:W] when high_i=1 and to product[W-1:0] when high_i=0; the lower half SHALL be identical for both signed modes.
REQ-010 SHALL treat an input handshake as in_valid_i && in_ready_o on a rising edge, and an output handshake as out_valid_o && out_ready_i.
REQ-011 SHALL define the pipeline advance enable as adv = !out_valid_o || out_ready_i, and SHALL drive in_ready_o = adv combinationally.
REQ-012 SHALL hold every pipeline stage (data, tag, mode, valid) unchanged on any cycle where adv=0.
REQ-013 SHALL assert out_valid_o exactly LATENCY advancing cycles after an accepted input; with out_ready_i held at 1, this is exactly LATENCY clock cycles.
REQ-014 SHALL sustain one accepted operation per cycle when out_ready_i=1, and SHALL preserve operation order.
REQ-015 SHALL keep c_o and tag_o stable while out_valid_o=1 and out_ready_i=0.
REQ-016 SHALL propagate a bubble through a stage whenever in_valid_i=0 on an advancing cycle; bubbles SHALL never produce out_valid_o=1.
REQ-017 SHALL drop nothing and duplicate nothing under any out_ready_i pattern.
REQ-018 SHALL capture signed_i, high_i, and tag_i with the operands and carry them down the pipeline with the operation.
REQ-019 SHALL be free of combinational paths from in_valid_i, a_i, or b_i to any output; the only combinational path SHALL be out_ready_i -> in_ready_o.

Reset
REQ-020 While rst_i=1 on a rising edge, SHALL clear every stage valid bit, so that out_valid_o=0 on the following cycle.
REQ-021 Operations in flight when rst_i is asserted SHALL be discarded and SHALL never appear at the output.
REQ-022 After reset, c_o and tag_o SHALL read 0.
REQ-023 During reset, in_ready_o SHALL follow REQ-011, so it reads 1.
REQ-024 An input offered in the same cycle as rst_i=1 SHALL NOT be accepted.

Verification (DATA_WIDTH=32, LATENCY=3)
REQ-025 Latency: a=3, b=5, unsigned, low, tag=0xA, out_ready=1 -> c_o=0x0000000F, tag_o=0xA, out_valid_o rising exactly 3 cycles after the handshake.
REQ-026 Modes: a=b=0xFFFFFFFF:
- signed, high -> 0x00000000; signed, low -> 0x00000001; unsigned, high -> 0xFFFFFFFE.
- a=0x80000000, b=1: signed, high -> 0xFFFFFFFF; unsigned, high -> 0x00000000.
REQ-027 Throughput: 16 back-to-back operations with out_ready=1 -> 16 results on 16 consecutive cycles, in order, with in_ready_o constantly 1.
REQ-028 Backpressure:
- Stream 6 operations while out_ready=0 for 5 cycles, then set out_ready=1.
- Required: in_ready_o=0 once the output stage is full.
- Required: c_o and tag_o held constant while stalled.
- Required: all 6 results delivered, in order, none lost or repeated.
REQ-029 Reset mid-flight: accept 3 operations, assert rst_i for 1 cycle while they are in flight -> out_valid_o=0 next cycle, none of the 3 results ever emitted, and a new operation accepted afterwards completes after 3 cycles.
REQ-030 Bubbles: alternate in_valid 1/0 for 10 cycles -> exactly 5 results, out_valid_o alternating, each result correct for its operands.
